uart_rx: RTL and testbench

Serial receiver for the asynchronous 8N1 UART link used by the adder/latch system. It complements the existing transmitter: it turns the line-level bit stream back into parallel words, so a second board or a loopback bench can capture the sums the system sends. It samples each bit at mid-bit with a clock-derived counter, and flags framing errors and line breaks.

---
 rtl/uart_rx.sv | 80 ++++++++
 tb/tb_uart_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and framing-error/break detection
module uart_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break
);
  localparam int CPB  = CLK_HZ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int IW   = PAYLOAD_BITS > 1 ? $clog2(PAYLOAD_BITS) : 1;
  typedef enum logic [2:0] {IDLE, START, RECV, STOP, WAIT_HIGH} state_t;
  state_t                  state_q, state_d;
  logic [1:0]              sync_q, sync_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic                    valid_q, valid_d, err_q, err_d, brk_q, brk_d;
  logic                    rxd_s, tick;
  assign rxd_s             = sync_q[1];
  assign uart_rx_data      = data_q;
  assign uart_rx_valid     = valid_q;
  assign uart_rx_frame_err = err_q;
  assign uart_rx_break     = brk_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      brk_q   <= brk_d;
    end
  end
  // tick marks the sampling cycle of the current bit
  always_comb begin
    tick    = (state_q == START && cnt_q == CW'(HALF - 1)) ||
              ((state_q == RECV || state_q == STOP) && cnt_q == CW'(CPB - 1));
    state_d = state_q;
    case (state_q)
      IDLE:      if (uart_rx_en && !rxd_s) state_d = START;
      START:     if (tick) state_d = rxd_s ? IDLE : RECV;
      RECV:      if (tick && idx_q == IW'(PAYLOAD_BITS - 1)) state_d = STOP;
      STOP:      if (tick) state_d = rxd_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxd_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    sync_d  = {sync_q[0], uart_rxd};
    cnt_d   = (tick || state_q == IDLE || state_q == WAIT_HIGH) ? '0 : cnt_q + 1'b1;
    idx_d   = state_q == START ? '0 : (state_q == RECV && tick) ? idx_q + 1'b1 : idx_q;
    sh_d    = (state_q == RECV && tick) ? {rxd_s, sh_q[PAYLOAD_BITS-1:1]} : sh_q;
    valid_d = state_q == STOP && tick && rxd_s;
    err_d   = state_q == STOP && tick && !rxd_s;
    brk_d   = err_d && sh_q == '0;
    data_d  = valid_d ? sh_q : data_q;
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenario bench for uart_rx at CPB=10, HALF=5
module tb_uart_rx;
  logic       clk = 1'b0, reset = 1'b1, uart_rxd = 1'b1, uart_rx_en = 1'b1;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid, uart_rx_frame_err, uart_rx_break;
  int         checks = 0, errors = 0;
  int         n_valid = 0, n_err = 0, n_brk = 0, n_eb = 0, n_ovl = 0;
  logic [7:0] rxq[$];
  always #5 clk = ~clk;
  uart_rx #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8)) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_frame_err(uart_rx_frame_err), .uart_rx_break(uart_rx_break));
  always @(negedge clk) begin
    if (uart_rx_valid) begin
      n_valid++;
      rxq.push_back(uart_rx_data);
    end
    if (uart_rx_frame_err) n_err++;
    if (uart_rx_break) n_brk++;
    if (uart_rx_frame_err && uart_rx_break) n_eb++;
    if (uart_rx_valid && uart_rx_frame_err) n_ovl++;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input int en_off);
    uart_rxd = 1'b0;
    cyc(10);
    for (int i = 0; i < 8; i++) begin
      if (i == en_off) uart_rx_en = 1'b0;
      uart_rxd = d[i];
      cyc(10);
    end
    uart_rxd = stop;
    cyc(10);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    uart_rxd = 1'b1;
    cyc(5);
    reset = 1'b0;
    cyc(1);
    checks++; if (uart_rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", uart_rx_data); end
    checks++; if (uart_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", uart_rx_valid); end
    checks++; if (uart_rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", uart_rx_frame_err); end
    checks++; if (uart_rx_break !== 1'b0) begin errors++; $display("FAIL reset_break got %b want 0", uart_rx_break); end
  endtask
  task automatic test_single;
    int lat = -1;
    int v0 = n_valid, e0 = n_err, b0 = n_brk;
    fork
      send_frame(8'h15, 1'b1, -1);
      begin
        for (int i = 1; i <= 200; i++) begin
          @(negedge clk);
          if (uart_rx_valid === 1'b1) begin
            lat = i;
            break;
          end
        end
      end
    join
    cyc(20);
    checks++; if (lat < 97 || lat > 99) begin errors++; $display("FAIL single_latency got %0d want 97..99", lat); end
    checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL single_valid_count got %0d want 1", n_valid - v0); end
    checks++; if (uart_rx_data !== 8'h15) begin errors++; $display("FAIL single_data got %h want 15", uart_rx_data); end
    checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL single_err_count got %0d want 0", n_err - e0); end
    checks++; if (n_brk - b0 != 0) begin errors++; $display("FAIL single_break_count got %0d want 0", n_brk - b0); end
  endtask
  task automatic test_back_to_back;
    int v0 = n_valid;
    send_frame(8'hA5, 1'b1, -1);
    send_frame(8'h3C, 1'b1, -1);
    cyc(20);
    checks++; if (n_valid - v0 != 2) begin errors++; $display("FAIL b2b_valid_count got %0d want 2", n_valid - v0); end
    checks++; if (rxq[rxq.size()-2] !== 8'hA5) begin errors++; $display("FAIL b2b_first got %h want a5", rxq[rxq.size()-2]); end
    checks++; if (rxq[rxq.size()-1] !== 8'h3C) begin errors++; $display("FAIL b2b_second got %h want 3c", rxq[rxq.size()-1]); end
  endtask
  task automatic test_frame_err;
    int v0 = n_valid, e0 = n_err, b0 = n_brk;
    send_frame(8'h5A, 1'b0, -1);
    cyc(200);
    uart_rxd = 1'b1;
    cyc(30);
    checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL ferr_err_count got %0d want 1", n_err - e0); end
    checks++; if (n_brk - b0 != 0) begin errors++; $display("FAIL ferr_break_count got %0d want 0", n_brk - b0); end
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL ferr_valid_count got %0d want 0", n_valid - v0); end
    checks++; if (uart_rx_data !== 8'h3C) begin errors++; $display("FAIL ferr_data_held got %h want 3c", uart_rx_data); end
    send_frame(8'h33, 1'b1, -1);
    cyc(20);
    checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL ferr_recover_count got %0d want 1", n_valid - v0); end
    checks++; if (uart_rx_data !== 8'h33) begin errors++; $display("FAIL ferr_recover_data got %h want 33", uart_rx_data); end
  endtask
  task automatic test_break;
    int v0 = n_valid, e0 = n_err, b0 = n_brk, eb0 = n_eb;
    uart_rxd = 1'b0;
    cyc(300);
    checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL break_err_count got %0d want 1", n_err - e0); end
    checks++; if (n_brk - b0 != 1) begin errors++; $display("FAIL break_count got %0d want 1", n_brk - b0); end
    checks++; if (n_eb - eb0 != 1) begin errors++; $display("FAIL break_same_cycle got %0d want 1", n_eb - eb0); end
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL break_valid_count got %0d want 0", n_valid - v0); end
    uart_rxd = 1'b1;
    cyc(30);
    checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL break_after_release got %0d want 1", n_err - e0); end
    checks++; if (uart_rx_data !== 8'h33) begin errors++; $display("FAIL break_data_held got %h want 33", uart_rx_data); end
  endtask
  task automatic test_glitch;
    int v0 = n_valid, e0 = n_err;
    uart_rxd = 1'b0;
    cyc(3);
    uart_rxd = 1'b1;
    cyc(30);
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", n_valid - v0); end
    checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL glitch_err got %0d want 0", n_err - e0); end
    send_frame(8'h96, 1'b1, -1);
    cyc(20);
    checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL glitch_recover_count got %0d want 1", n_valid - v0); end
    checks++; if (uart_rx_data !== 8'h96) begin errors++; $display("FAIL glitch_recover_data got %h want 96", uart_rx_data); end
  endtask
  task automatic test_enable;
    int v0 = n_valid, e0 = n_err;
    uart_rx_en = 1'b0;
    send_frame(8'hFF, 1'b1, -1);
    cyc(20);
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL en_off_valid got %0d want 0", n_valid - v0); end
    checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL en_off_err got %0d want 0", n_err - e0); end
    uart_rx_en = 1'b1;
    cyc(5);
    send_frame(8'h81, 1'b1, 3);
    uart_rx_en = 1'b1;
    cyc(20);
    checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL en_drop_count got %0d want 1", n_valid - v0); end
    checks++; if (uart_rx_data !== 8'h81) begin errors++; $display("FAIL en_drop_data got %h want 81", uart_rx_data); end
  endtask
  task automatic test_reset_mid;
    int q0 = rxq.size();
    int v0;
    int seen77 = 0;
    fork
      send_frame(8'h77, 1'b1, -1);
      begin
        cyc(55);
        reset = 1'b1;
        cyc(1);
        checks++; if (uart_rx_data !== 8'h00) begin errors++; $display("FAIL rmid_data got %h want 00", uart_rx_data); end
        checks++; if (uart_rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", uart_rx_valid); end
        checks++; if (uart_rx_frame_err !== 1'b0) begin errors++; $display("FAIL rmid_err got %b want 0", uart_rx_frame_err); end
        checks++; if (uart_rx_break !== 1'b0) begin errors++; $display("FAIL rmid_break got %b want 0", uart_rx_break); end
        reset = 1'b0;
      end
    join
    cyc(150);
    for (int i = q0; i < rxq.size(); i++) if (rxq[i] === 8'h77) seen77++;
    checks++; if (seen77 != 0) begin errors++; $display("FAIL rmid_partial_frame got %0d want 0", seen77); end
    v0 = n_valid;
    send_frame(8'h42, 1'b1, -1);
    cyc(20);
    checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL rmid_next_count got %0d want 1", n_valid - v0); end
    checks++; if (uart_rx_data !== 8'h42) begin errors++; $display("FAIL rmid_next_data got %h want 42", uart_rx_data); end
  endtask
  task automatic test_exclusive;
    checks++; if (n_ovl != 0) begin errors++; $display("FAIL valid_err_overlap got %0d want 0", n_ovl); end
    checks++; if (n_brk != n_eb) begin errors++; $display("FAIL break_without_err got %0d want %0d", n_brk, n_eb); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_frame_err;
    test_break;
    test_glitch;
    test_enable;
    test_reset_mid;
    test_exclusive;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
